// File: rtl/mux_2.sv
// mux_2: parameterised 2:1 word multiplexer with a clocked debug side-channel.
// o_y is purely combinational. The registered copies of o_y and i_s and the
// saturating select-toggle counter are used only for observability.

// One bit slice of the datapath mux.
module mux_2_bit (
  input  logic i_d0,
  input  logic i_d1,
  input  logic i_s,
  output logic o_y
);
  assign o_y = i_s ? i_d1 : i_d0;
endmodule

module mux_2 #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [WIDTH-1:0]     i_d0,
  input  logic [WIDTH-1:0]     i_d1,
  input  logic                 i_s,
  input  logic                 i_en,
  input  logic                 i_cnt_clr,
  output logic [WIDTH-1:0]     o_y,
  output logic [WIDTH-1:0]     o_y_q,
  output logic                 o_s_q,
  output logic [CNT_WIDTH-1:0] o_toggle_cnt,
  output logic                 o_cnt_sat
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  // Combinational datapath: one slice per bit, no clock or reset involvement.
  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    mux_2_bit u_bit (
      .i_d0 (i_d0[b]),
      .i_d1 (i_d1[b]),
      .i_s  (i_s),
      .o_y  (o_y[b])
    );
  end

  logic [WIDTH-1:0]     y_q_q,   y_q_d;
  logic                 s_q_q,   s_q_d;
  logic                 s_prev_q, s_prev_d;
  logic [CNT_WIDTH-1:0] cnt_q,   cnt_d;
  logic                 cnt_sat;

  assign cnt_sat = (cnt_q == CNT_MAX);

  // Next-state: enabled capture of the mux output and select.
  always_comb begin
    y_q_d = y_q_q;
    s_q_d = s_q_q;
    if (i_en) begin
      y_q_d = o_y;
      s_q_d = i_s;
    end
  end

  // Next-state: s_prev tracks i_s every cycle; clear beats increment; saturate at max.
  always_comb begin
    s_prev_d = i_s;
    cnt_d    = cnt_q;
    if (i_cnt_clr)
      cnt_d = '0;
    else if ((i_s != s_prev_q) && !cnt_sat)
      cnt_d = cnt_q + CNT_ONE;
  end

  // Side-channel registers, cleared asynchronously.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      y_q_q    <= '0;
      s_q_q    <= 1'b0;
      s_prev_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      y_q_q    <= y_q_d;
      s_q_q    <= s_q_d;
      s_prev_q <= s_prev_d;
      cnt_q    <= cnt_d;
    end
  end

  assign o_y_q        = y_q_q;
  assign o_s_q        = s_q_q;
  assign o_toggle_cnt = cnt_q;
  assign o_cnt_sat    = cnt_sat;

endmodule

// File: tb/tb_mux_2.sv
// Directed bench for mux_2: a default-width instance plus a CNT_WIDTH=2
// instance sharing the same stimulus to exercise counter saturation.
module tb_mux_2;

  logic        clk = 1'b0;
  logic        clk_run = 1'b0;
  logic        rst_n;
  logic [31:0] d0, d1;
  logic        s, en, clr;

  logic [31:0] y, yq, y2, yq2;
  logic        sq, sat, sq2, sat2;
  logic [15:0] cnt;
  logic [1:0]  cnt2;

  int checks = 0;
  int failures = 0;

  mux_2 #(.WIDTH(32), .CNT_WIDTH(16)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_d0(d0), .i_d1(d1), .i_s(s),
    .i_en(en), .i_cnt_clr(clr), .o_y(y), .o_y_q(yq), .o_s_q(sq),
    .o_toggle_cnt(cnt), .o_cnt_sat(sat)
  );

  mux_2 #(.WIDTH(32), .CNT_WIDTH(2)) u_dut_sat (
    .i_clk(clk), .i_rst_n(rst_n), .i_d0(d0), .i_d1(d1), .i_s(s),
    .i_en(en), .i_cnt_clr(clr), .o_y(y2), .o_y_q(yq2), .o_s_q(sq2),
    .o_toggle_cnt(cnt2), .o_cnt_sat(sat2)
  );

  // Clock only runs once clk_run is set, so the first steps see no edges.
  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; d0 = 32'h1; d1 = 32'h2; s = 1'b0; en = 1'b0; clr = 1'b0;

    // Combinational path and reset state, clock stopped.
    #1;
    chk("comb_s0", y, 32'h1);
    chk("rst_yq", yq, 0);
    chk("rst_sq", sq, 0);
    chk("rst_cnt", cnt, 0);
    chk("rst_sat", sat, 0);
    chk("rst_sat_small", sat2, 0);
    s = 1'b1; #1;
    chk("comb_s1", y, 32'h2);
    d1 = 32'hDEADBEEF; #1;
    chk("comb_d1_chg", y, 32'hDEADBEEF);
    d0 = 32'h00001234; #1;
    chk("comb_d0_noeff", y, 32'hDEADBEEF);
    chk("comb_small", y2, 32'hDEADBEEF);

    // Release reset with s=0, then start the clock.
    s = 1'b0; d1 = 32'h2; rst_n = 1'b1; clk_run = 1'b1;
    tick;
    chk("rel_cnt", cnt, 0);

    // Registered capture.
    en = 1'b1; s = 1'b1;
    tick;
    chk("reg_yq", yq, 32'h2);
    chk("reg_sq", sq, 1);
    chk("reg_cnt1", cnt, 1);

    // Hold with en=0.
    en = 1'b0; s = 1'b0; d0 = 32'h55; d1 = 32'h77;
    tick;
    chk("hold_yq", yq, 32'h2);
    chk("hold_sq", sq, 1);
    chk("hold_cnt2", cnt, 2);
    chk("hold_cnt2_small", cnt2, 2);
    chk("hold_sat_small", sat2, 0);
    chk("comb_follow", y, 32'h55);

    clr = 1'b1;
    tick;
    chk("clr_cnt", cnt, 0);
    clr = 1'b0;

    // Five toggles from s=0.
    for (int i = 0; i < 5; i++) begin
      s = ~s;
      tick;
    end
    chk("tog5_cnt", cnt, 5);
    chk("tog5_sat", sat, 0);
    chk("tog5_cnt_small", cnt2, 3);
    chk("tog5_sat_small", sat2, 1);

    // Clear together with a toggle: clear wins.
    s = ~s; clr = 1'b1;
    tick;
    chk("clr_tog_cnt", cnt, 0);
    chk("clr_tog_cnt_small", cnt2, 0);
    chk("clr_tog_sat_small", sat2, 0);
    clr = 1'b0;

    // Six toggles: small counter saturates and holds.
    for (int i = 0; i < 6; i++) begin
      s = ~s;
      tick;
    end
    chk("tog6_cnt", cnt, 6);
    chk("tog6_cnt_small", cnt2, 3);
    chk("tog6_sat_small", sat2, 1);
    tick;
    chk("hold6_cnt", cnt, 6);
    chk("hold6_cnt_small", cnt2, 3);

    // Mid-cycle async reset with s raised.
    #2;
    rst_n = 1'b0; s = 1'b1;
    #1;
    chk("mrst_yq", yq, 0);
    chk("mrst_sq", sq, 0);
    chk("mrst_cnt", cnt, 0);
    chk("mrst_cnt_small", cnt2, 0);
    chk("mrst_sat_small", sat2, 0);
    chk("mrst_y", y, 32'h77);
    tick;
    chk("mrst_held_cnt", cnt, 0);

    // s held at 1 through reset counts one toggle on release.
    rst_n = 1'b1;
    tick;
    chk("rel_s1_cnt", cnt, 1);
    chk("rel_s1_cnt_small", cnt2, 1);
    chk("rel_s1_sq", sq, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
